accumulator_frame_ctrl: RTL

//  Sequences one accumulator instance over frames of samples. On start: clears
//  the accumulator, latches frame length and add/sub mode, then streams
//  cfg_len samples (valid/ready) into it. Waits out the accumulator latency,

---
 rtl/accumulator_frame_ctrl_if.sv | 36 +++
 rtl/accumulator_frame_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/accumulator_frame_ctrl_if.sv
// Bundle of the three data-path ports around the frame controller:
//   sample stream in (s_*), accumulator control/result (acc_*), frame
//   result out (m_*). The controller takes the slave view; the sample
//   source, accumulator and result sink together take the master view.
interface accumulator_frame_ctrl_if #(
  parameter int DATA_W = 20,
  parameter int ACC_W  = 38
) ();

  // Sample stream (signed samples)
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  // Accumulator instance owned by the controller
  logic              acc_clr;
  logic              acc_sub;
  logic [DATA_W-1:0] acc_a;
  logic [ACC_W-1:0]  acc_p;

  // Frame result (signed)
  logic              m_valid;
  logic [ACC_W-1:0]  m_data;
  logic              m_ready;

  modport master (
    output s_valid, s_data, acc_p, m_ready,
    input  s_ready, acc_clr, acc_sub, acc_a, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, acc_p, m_ready,
    output s_ready, acc_clr, acc_sub, acc_a, m_valid, m_data
  );

endinterface

// File: rtl/accumulator_frame_ctrl.sv
// Frame sequencer for a single multiply-free accumulator instance.
// A frame is: clear the accumulator, stream cfg_len samples into its A
// operand (add or subtract mode fixed for the frame), wait out the
// accumulator latency, then hold the P result on a valid/ready port
// until it is taken. No saturation: P wraps at ACC_W bits.
module accumulator_frame_ctrl #(
  parameter int DATA_W  = 20,
  parameter int ACC_W   = 38,
  parameter int LEN_W   = 8,
  parameter int ACC_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,    // asynchronous, active-low
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_sub,
  output logic                 busy,
  accumulator_frame_ctrl_if.slave bus
);

  // Drain counter only has to reach ACC_LAT-1; keep at least one bit.
  localparam int DRN_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(ACC_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    OUT
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic               sub_q,   sub_d;
  logic [LEN_W-1:0]   beat_q,  beat_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic               m_valid_q, m_valid_d;
  logic [ACC_W-1:0]   m_data_q,  m_data_d;

  // State register plus frame configuration, counters and result holding.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of every other register, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      sub_q     <= 1'b0;
      beat_q    <= '0;
      drain_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sub_q     <= sub_d;
      beat_q    <= beat_d;
      drain_q   <= drain_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // Next-state logic and the accumulator/stream control outputs.
  // A is forced to zero whenever no sample transfers, so P simply holds.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    sub_d       = sub_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    busy        = (state_q != IDLE);
    bus.s_ready = 1'b0;
    bus.acc_clr = 1'b0;
    bus.acc_sub = 1'b0;
    bus.acc_a   = '0;

    unique case (state_q)
      IDLE: begin
        // A zero-length frame is meaningless; ignore that start entirely.
        if (start && (cfg_len != '0)) begin
          len_d   = cfg_len;
          sub_d   = cfg_sub;
          beat_d  = '0;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        bus.acc_clr = 1'b1;
        bus.acc_sub = sub_q;
        state_d     = RUN;
      end

      RUN: begin
        bus.s_ready = 1'b1;
        bus.acc_sub = sub_q;
        if (bus.s_valid) begin
          bus.acc_a = bus.s_data;
          if (beat_q == len_q - LEN_W'(1)) begin
            beat_d  = '0;
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end

      DRAIN: begin
        // The last sample reaches P ACC_LAT edges after it was presented;
        // capture P at the end of the final drain cycle.
        bus.acc_sub = sub_q;
        if (drain_q == DRN_LAST) begin
          drain_d   = '0;
          m_data_d  = bus.acc_p;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end

      OUT: begin
        bus.acc_sub = sub_q;
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;

endmodule
